// File: rtl/event_encoder.sv
// Clocked 8-to-3 event encoder: synchronises eight request lines, captures rising
// edges into a pending mask and serialises them as 3-bit indices over valid/ready.
// Define EVENT_ENCODER_RR_EN for round-robin selection instead of fixed 7-high priority.
module event_encoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iData,
  input  logic       iEna,
  input  logic       iReady,
  input  logic       iClrOvf,
  output logic [2:0] oData,
  output logic       oValid,
  output logic [7:0] oPending,
  output logic       oOverflow
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] prev_q;
  logic [7:0] pending_q, pending_d;
  logic [2:0] data_q;
  logic       ovf_q;

  logic [7:0] rise;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;
  logic       ovf_hit;
  logic       load;
  logic [2:0] pick_idx;

  // Synchroniser chain plus the previous-value register used for edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= iData;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

`ifdef EVENT_ENCODER_RR_EN
  logic [2:0] ptr_q;

  // Search from last+1 upward with wrap; descending offsets so the nearest one wins.
  function automatic logic [2:0] pick_rr(input logic [7:0] mask, input logic [2:0] last);
    logic [2:0] idx;
    pick_rr = '0;
    for (int k = 8; k >= 1; k--) begin
      idx = last + k[2:0];
      if (mask[idx]) pick_rr = idx;
    end
  endfunction

  assign pick_idx = pick_rr(pending_q, ptr_q);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)   ptr_q <= 3'd7;
    else if (load) ptr_q <= pick_idx;
  end
`else
  // Fixed priority, index 7 highest: later loop iterations override earlier ones.
  function automatic logic [2:0] pick_fixed(input logic [7:0] mask);
    pick_fixed = '0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) pick_fixed = 3'(i);
    end
  endfunction

  assign pick_idx = pick_fixed(pending_q);
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          load    = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (iReady) begin
          if (|pending_q) load    = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge on the line being granted re-arms it and is not an overflow.
  always_comb begin
    set_mask  = iEna ? rise : 8'd0;
    clr_mask  = load ? (8'd1 << pick_idx) : 8'd0;
    ovf_hit   = |(set_mask & pending_q & ~clr_mask);
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (load) data_q <= pick_idx;
      if (ovf_hit)      ovf_q <= 1'b1;
      else if (iClrOvf) ovf_q <= 1'b0;
    end
  end

  assign oData     = data_q;
  assign oValid    = (state_q == VALID);
  assign oPending  = pending_q;
  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_event_encoder.sv
// Self-checking bench for event_encoder: directed scenarios plus randomized traffic
// compared every cycle against a cycle-level behavioural model.
module tb_event_encoder;

  localparam int S = 2;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic [7:0] iData;
  logic       iEna;
  logic       iReady;
  logic       iClrOvf;
  logic [2:0] oData;
  logic       oValid;
  logic [7:0] oPending;
  logic       oOverflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: history of sampled inputs (index 0 newest), pending set, output slot.
  logic [7:0] h [S+2];
  logic [7:0] m_pend;
  logic       m_valid;
  int         m_data;
  logic       m_ovf;
  int         m_last;
  int         acc_q[$];

  event_encoder #(.SYNC_STAGES(S)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iData     (iData),
    .iEna      (iEna),
    .iReady    (iReady),
    .iClrOvf   (iClrOvf),
    .oData     (oData),
    .oValid    (oValid),
    .oPending  (oPending),
    .oOverflow (oOverflow)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int choose(input logic [7:0] p, input int last);
`ifdef EVENT_ENCODER_RR_EN
    for (int k = 1; k <= 8; k++) begin
      if (p[(last + k) % 8]) return (last + k) % 8;
    end
`else
    for (int i = 7; i >= 0; i--) begin
      if (p[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < S + 2; j++) h[j] = '0;
    m_pend  = '0;
    m_valid = 1'b0;
    m_data  = 0;
    m_ovf   = 1'b0;
    m_last  = 7;
  endtask

  task automatic model_step();
    logic [7:0] r;
    logic       ovf_ev;
    int         pick;
    for (int j = S + 1; j > 0; j--) h[j] = h[j-1];
    h[0] = iData;
    // A line seen rising S edges ago becomes pending now.
    r = iEna ? (h[S] & ~h[S+1]) : 8'd0;
    if (m_valid && iReady) acc_q.push_back(m_data);
    pick = -1;
    if ((!m_valid || iReady) && m_pend != 0) pick = choose(m_pend, m_last);
    ovf_ev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (r[i] && m_pend[i] && i != pick) ovf_ev = 1'b1;
    end
    if (pick >= 0) begin
      m_pend[pick] = 1'b0;
      m_data  = pick;
      m_valid = 1'b1;
      m_last  = pick;
    end else if (m_valid && iReady) begin
      m_valid = 1'b0;
    end
    m_pend = m_pend | r;
    if (ovf_ev)       m_ovf = 1'b1;
    else if (iClrOvf) m_ovf = 1'b0;
  endtask

  task automatic compare();
    chk("valid",    int'(oValid),    int'(m_valid));
    chk("pending",  int'(oPending),  int'(m_pend));
    chk("overflow", int'(oOverflow), int'(m_ovf));
    if (m_valid) chk("data", int'(oData), m_data);
  endtask

  task automatic tick();
    @(posedge iClk);
    model_step();
    @(negedge iClk);
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"},     int'(oData),     0);
    chk({tag, "_valid"},    int'(oValid),    0);
    chk({tag, "_pending"},  int'(oPending),  0);
    chk({tag, "_overflow"}, int'(oOverflow), 0);
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    check_zero("reset");
    model_reset();
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  // Counts cycles with oValid high over n ticks and returns the first such tick (1-based).
  task automatic watch(input int n, output int nv, output int first, output int last_d);
    nv = 0; first = -1; last_d = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (oValid) begin
        nv++;
        if (first < 0) first = i;
        last_d = int'(oData);
      end
    end
  endtask

  initial begin
    int nv, first, ld;
    int exp_seq[4];

    iRst_n = 1'b0; iData = '0; iEna = 1'b1; iReady = 1'b1; iClrOvf = 1'b0;
    model_reset();
    #1;
    check_zero("por");
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;

    // Single 4-cycle pulse on line 0: one event, valid at edge k+3.
    iData = 8'h01;
    ticks(2);
    watch(2, nv, first, ld);
    iData = 8'h00;
    chk("t1_first_valid_tick", first, 2);
    watch(6, nv, first, ld);
    chk("t1_valid_after", nv, 0);
    chk("t1_pending_end", int'(oPending), 0);

    // Simultaneous edges on 0,2,5,7 drain back-to-back.
`ifdef EVENT_ENCODER_RR_EN
    exp_seq = '{0, 2, 5, 7};
`else
    exp_seq = '{7, 5, 2, 0};
`endif
    do_reset();
    acc_q.delete();
    iData = 8'hA5;
    watch(10, nv, first, ld);
    chk("t2_valid_cycles", nv, 4);
    chk("t2_accepted", acc_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_seq%0d", i), (acc_q.size() > i) ? acc_q[i] : -1, exp_seq[i]);
    iData = 8'h00;
    ticks(4);

    // Back-pressure: held output while a new edge arrives on line 3.
    do_reset();
    iReady = 1'b0;
    iData  = 8'h02;
    ticks(5);
    chk("t3_hold_valid", int'(oValid), 1);
    chk("t3_hold_data", int'(oData), 1);
    iData = 8'h0A;
    ticks(4);
    chk("t3_pending3", int'(oPending), 8'h08);
    chk("t3_still_data", int'(oData), 1);
    acc_q.delete();
    iReady = 1'b1;
    ticks(4);
    chk("t3_accepted", acc_q.size(), 2);
    chk("t3_acc0", (acc_q.size() > 0) ? acc_q[0] : -1, 1);
    chk("t3_acc1", (acc_q.size() > 1) ? acc_q[1] : -1, 3);

    // Overflow: second edge on line 4 while still pending.
    do_reset();
    iReady = 1'b0;
    iData  = 8'h02;
    ticks(5);
    iData = 8'h12;
    ticks(4);
    chk("t4_pending4", int'(oPending), 8'h10);
    chk("t4_no_ovf_yet", int'(oOverflow), 0);
    iData = 8'h02;
    ticks(4);
    iData = 8'h12;
    ticks(4);
    chk("t4_ovf_set", int'(oOverflow), 1);
    chk("t4_pending_once", int'(oPending), 8'h10);
    acc_q.delete();
    iReady = 1'b1;
    ticks(5);
    chk("t4_accepted", acc_q.size(), 2);
    chk("t4_acc_line4", (acc_q.size() > 1) ? acc_q[1] : -1, 4);
    chk("t4_ovf_sticky", int'(oOverflow), 1);
    iClrOvf = 1'b1;
    tick();
    iClrOvf = 1'b0;
    chk("t4_ovf_cleared", int'(oOverflow), 0);

    // Capture disabled: the edge is dropped and not replayed later.
    do_reset();
    iEna  = 1'b0;
    iData = 8'h40;
    watch(6, nv, first, ld);
    chk("t5_disabled", nv, 0);
    iEna = 1'b1;
    watch(6, nv, first, ld);
    chk("t5_reenabled", nv, 0);
    iData = 8'h00;
    ticks(4);

    // Reset in mid-handshake discards everything.
    do_reset();
    iReady = 1'b0;
    iData  = 8'h01;
    ticks(5);
    iData = 8'h13;
    ticks(4);
    chk("t6_pending", int'(oPending), 8'h12);
    chk("t6_valid", int'(oValid), 1);
    iData = 8'h00;
    do_reset();
    iReady = 1'b1;
    watch(10, nv, first, ld);
    chk("t6_no_events", nv, 0);

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) iData = 8'($urandom);
      iReady  = ($urandom_range(0, 3) != 0);
      iEna    = ($urandom_range(0, 7) != 0);
      iClrOvf = ($urandom_range(0, 15) == 0);
      if (c % 700 == 699) do_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/event_encoder.md
# event_encoder

Clocked 8-to-3 event encoder: the transmit-side counterpart of the 3-8 decoder. Captures rising edges on eight asynchronous request lines into a pending mask and emits one 3-bit index per event over a valid/ready handshake. Used wherever eight discrete sources (buttons, flags, decoder outputs looped back) must be serialised into a single index stream.

## Interface
- SYNC_STAGES, 2, synchroniser depth on iData; legal 2..3

- iClk  in  1  clock; all state on rising edge
- iRst_n  in  1  asynchronous active-low reset
- iData  in  8  request lines, asynchronous to iClk
- iEna  in  1  capture enable; 0 = new edges ignored
- iReady  in  1  consumer accepts oData when high with oValid
- iClrOvf  in  1  synchronous clear of oOverflow
- oData  out  3  encoded index of current event
- oValid  out  1  oData holds an unconsumed event
- oPending  out  8  pending-event mask, excluding the event in oData
- oOverflow  out  1  sticky: an edge hit an already-pending line

## Operation
- iData passes through SYNC_STAGES flops, then a previous-value register; edge[i] = sync[i] & ~prev[i].
- When iEna=1, each edge[i] sets pending[i]. When iEna=0, edges are dropped; existing pending bits still drain.
- edge[i] while pending[i]=1 (and iEna=1): pending unchanged, oOverflow set.
- FSM, 2 states:
  - IDLE (oValid=0): if pending≠0, select index per priority rule, load oData, clear that pending bit, go to VALID.
  - VALID (oValid=1): oData and oValid held stable while iReady=0. On oValid&iReady: if pending≠0, load next index same cycle (stay VALID, back-to-back); else go to IDLE, oValid=0.
- Default priority: fixed, index 7 highest, 0 lowest (74x148 order).
- Same-cycle set and clear of one pending bit (new edge on the line being loaded): set wins, bit stays 1; no overflow.
- Same-cycle iClrOvf and overflow event: set wins.
- oPending reflects the registered mask.

## Timing
- Reset (async assert, sync-style release): oData=0, oValid=0, oPending=0, oOverflow=0, sync and prev registers=0, FSM=IDLE.
- A line already high at reset release produces exactly one event.
- iData rising before clock edge k: pending bit set at edge k+SYNC_STAGES; oValid rises at edge k+SYNC_STAGES+1 if FSM was IDLE.
- Handshake throughput: one event per cycle with iReady held high.
- Minimum iData high and low pulse: SYNC_STAGES+1 cycles; shorter pulses may be lost.
- Reset mid-handshake discards oData and all pending events.

## Configuration
- EVENT_ENCODER_RR_EN defined: round-robin priority; search starts at (last granted index + 1) mod 8, ascending with wrap; last-granted pointer resets to 7 (so index 0 wins first).
- Not defined: fixed priority, index 7 highest; no pointer register.

## Test plan
- Reset, then pulse iData=8'h01 for 4 cycles, iEna=1, iReady=1 -> oValid high one cycle at edge k+3 with oData=0; oPending=0.
- iData rises 8'h00->8'hA5 in one cycle, iReady=1 -> oData sequence 7,5,2,0 on consecutive cycles (fixed); with EVENT_ENCODER_RR_EN: 0,2,5,7.
- iReady=0 with event pending, new edge on line 3 -> oData/oValid stable, oPending[3]=1; raise iReady -> two accepted transfers.
- Second edge on line 4 while pending[4]=1 -> oOverflow=1, one event for 4; iClrOvf pulse -> oOverflow=0 next cycle.
- iEna=0, edge on line 6 -> no event; iEna=1 afterwards, no edge -> still none.
- Assert iRst_n=0 while oValid=1 and oPending=8'h12 -> all outputs 0 immediately, no events after release.
